// File: rtl/dpram_port_req_buffer.sv
// dpram_port_req_buffer: in-order command queue in front of one dpram port, with
// credit-limited read-response buffering. Optional counters: DPRAM_REQ_STATS_EN.
module dpram_port_req_buffer #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int READ_LAT  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_we,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    input  logic [DW-1:0] mem_q,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          busy
`ifdef DPRAM_REQ_STATS_EN
    ,
    output logic [31:0]   stat_wr_cnt,
    output logic [31:0]   stat_rd_cnt
`endif
);
    localparam int CPW = $clog2(CMD_DEPTH);
    localparam int RPW = $clog2(RSP_DEPTH);
    localparam int CW  = $clog2(RSP_DEPTH + 1);
    localparam logic [CPW:0]  CMD_PTR_ONE = (CPW + 1)'(1);
    localparam logic [RPW:0]  RSP_PTR_ONE = (RPW + 1)'(1);
    localparam logic [CW-1:0] CREDIT_ONE  = CW'(1);
    localparam logic [CW-1:0] CREDIT_MAX  = CW'(RSP_DEPTH);

    logic          cmd_we_q   [CMD_DEPTH];
    logic [AW-1:0] cmd_addr_q [CMD_DEPTH];
    logic [DW-1:0] cmd_data_q [CMD_DEPTH];
    logic [DW-1:0] rsp_mem_q  [RSP_DEPTH];
    logic [CPW:0]  cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
    logic [RPW:0]  rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d;
    logic [CW-1:0] credits_q, credits_d;
    logic [READ_LAT-1:0] rd_pipe_q, rd_pipe_d;
    logic [CPW-1:0] cmd_head;
    logic [RPW-1:0] rsp_head;
    logic cmd_empty, cmd_full, rsp_empty, rsp_full;
    logic cmd_push, cmd_pop, rd_issue, rsp_push, rsp_pop;

    assign cmd_head  = cmd_rp_q[CPW-1:0];
    assign rsp_head  = rsp_rp_q[RPW-1:0];
    assign cmd_empty = (cmd_wp_q == cmd_rp_q);
    assign cmd_full  = (cmd_wp_q[CPW] != cmd_rp_q[CPW]) && (cmd_wp_q[CPW-1:0] == cmd_rp_q[CPW-1:0]);
    assign rsp_empty = (rsp_wp_q == rsp_rp_q);
    assign rsp_full  = (rsp_wp_q[RPW] != rsp_rp_q[RPW]) && (rsp_wp_q[RPW-1:0] == rsp_rp_q[RPW-1:0]);

    // Handshakes: a transfer happens on any cycle where valid && ready at the rising edge.
    assign in_ready  = !cmd_full && !rst;
    assign cmd_push  = in_valid && in_ready;
    assign mem_we    = cmd_we_q[cmd_head];
    assign mem_addr  = cmd_addr_q[cmd_head];
    assign mem_data  = cmd_data_q[cmd_head];
    assign mem_valid = !cmd_empty && (mem_we || credits_q != '0);
    assign cmd_pop   = mem_valid && mem_ready;
    assign rd_issue  = cmd_pop && !mem_we;
    assign rsp_push  = rd_pipe_q[READ_LAT-1];
    assign rsp_valid = !rsp_empty;
    assign rsp_data  = rsp_mem_q[rsp_head];
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign busy      = !cmd_empty || (|rd_pipe_q) || !rsp_empty;

    always_comb begin
        cmd_wp_d  = cmd_push ? cmd_wp_q + CMD_PTR_ONE : cmd_wp_q;
        cmd_rp_d  = cmd_pop  ? cmd_rp_q + CMD_PTR_ONE : cmd_rp_q;
        rsp_wp_d  = rsp_push ? rsp_wp_q + RSP_PTR_ONE : rsp_wp_q;
        rsp_rp_d  = rsp_pop  ? rsp_rp_q + RSP_PTR_ONE : rsp_rp_q;
        credits_d = credits_q;
        if (rd_issue && !rsp_pop) begin
            credits_d = credits_q - CREDIT_ONE;
        end else if (!rd_issue && rsp_pop) begin
            credits_d = credits_q + CREDIT_ONE;
        end
    end

    generate
        if (READ_LAT == 1) begin : g_lat1
            assign rd_pipe_d = rd_issue;
        end else begin : g_latn
            assign rd_pipe_d = {rd_pipe_q[READ_LAT-2:0], rd_issue};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CMD_DEPTH; i++) begin
                cmd_we_q[i]   <= 1'b0;
                cmd_addr_q[i] <= '0;
                cmd_data_q[i] <= '0;
            end
            for (int i = 0; i < RSP_DEPTH; i++) begin
                rsp_mem_q[i] <= '0;
            end
            cmd_wp_q  <= '0;
            cmd_rp_q  <= '0;
            rsp_wp_q  <= '0;
            rsp_rp_q  <= '0;
            credits_q <= CREDIT_MAX;
            rd_pipe_q <= '0;
        end else begin
            if (cmd_push) begin
                cmd_we_q[cmd_wp_q[CPW-1:0]]   <= in_we;
                cmd_addr_q[cmd_wp_q[CPW-1:0]] <= in_addr;
                cmd_data_q[cmd_wp_q[CPW-1:0]] <= in_data;
            end
            if (rsp_push) begin
                rsp_mem_q[rsp_wp_q[RPW-1:0]] <= mem_q;
            end
            cmd_wp_q  <= cmd_wp_d;
            cmd_rp_q  <= cmd_rp_d;
            rsp_wp_q  <= rsp_wp_d;
            rsp_rp_q  <= rsp_rp_d;
            credits_q <= credits_d;
            rd_pipe_q <= rd_pipe_d;
        end
    end

    // Credits reserve a response slot at issue, so a capture can never find the FIFO full.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(rsp_push && rsp_full)) else $error("response fifo overflow");
        end
    end

`ifdef DPRAM_REQ_STATS_EN
    logic [31:0] stat_wr_q, stat_rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_wr_q <= '0;
            stat_rd_q <= '0;
        end else begin
            if (cmd_pop && mem_we && stat_wr_q != 32'hFFFF_FFFF) begin
                stat_wr_q <= stat_wr_q + 32'd1;
            end
            if (rd_issue && stat_rd_q != 32'hFFFF_FFFF) begin
                stat_rd_q <= stat_rd_q + 32'd1;
            end
        end
    end

    assign stat_wr_cnt = stat_wr_q;
    assign stat_rd_cnt = stat_rd_q;
`endif

endmodule
